latency_implication_checker: RTL and testbench

- Synthesizable, always-on version of the "a implies b exactly LATENCY cycles later" property.
- It observes a request signal `a` and a response signal `b` and produces registered pass and fail pulses.
- It also keeps saturating pass and fail counters, a sticky error flag, and the start cycle of the first failure.
- It sits downstream of the DUT's a/b outputs, so the same check runs in silicon, emulation and gate-level sim without SVA support.

---
 rtl/latency_implication_checker_if.sv | 32 +++
 rtl/latency_implication_checker.sv | 119 +++++++++++
 tb/tb_latency_implication_checker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/latency_implication_checker_if.sv
// Observation bus for the latency implication checker: the monitored
// request/response pair with its controls, and the checker's results.
interface latency_implication_checker_if #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
);
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic             pass_o;
    logic             fail_o;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err_sticky;
    logic [TS_W-1:0]  first_fail_start;
    logic [TS_W-1:0]  cyc;

    // Side that drives a/b and the controls and watches the verdicts.
    modport master (
        output en, clr, a, b,
        input  pass_o, fail_o, pass_cnt, fail_cnt, err_sticky,
               first_fail_start, cyc
    );

    // The checker itself.
    modport slave (
        input  en, clr, a, b,
        output pass_o, fail_o, pass_cnt, fail_cnt, err_sticky,
               first_fail_start, cyc
    );
endinterface

// File: rtl/latency_implication_checker.sv
// Always-on "a implies b exactly LATENCY edges later" checker. Every
// sampled antecedent launches an obligation into a LATENCY-deep pipe
// together with its start timestamp; when it reaches the end, b at that
// edge decides pass or fail. Results are registered one-cycle pulses
// plus saturating counters and a capture of the first failure.
module latency_implication_checker #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 32
) (
    input logic clk,
    input logic rst_n,
    latency_implication_checker_if.slave bus
);

    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [LATENCY-1:0] pend_r;
    logic [TS_W-1:0]    ts_r [LATENCY];
    logic [TS_W-1:0]    cyc_r;
    logic               pass_r;
    logic               fail_r;
    logic [CNT_W-1:0]   pass_cnt_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic               err_sticky_r;
    logic [TS_W-1:0]    first_fail_start_r;

    logic               mature_s;
    logic               pass_s;
    logic               fail_s;

    // Verdict for the obligation reaching the end of the pipe; clr discards it.
    always_comb begin
        mature_s = pend_r[LATENCY-1];
        pass_s   = 1'b0;
        fail_s   = 1'b0;
        if (mature_s && !bus.clr) begin
            pass_s = bus.b;
            fail_s = ~bus.b;
        end else begin
            pass_s = 1'b0;
            fail_s = 1'b0;
        end
    end

    // Free-running edge counter that sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r <= '0;
        end else if (cyc_r != '1) begin
            cyc_r <= cyc_r + TS_ONE;
        end
    end

    // Obligation valid bits and their start timestamps move in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                ts_r[i] <= '0;
            end
        end else begin
            ts_r[0] <= cyc_r;
            for (int i = 1; i < LATENCY; i++) begin
                ts_r[i] <= ts_r[i-1];
            end
            if (bus.clr) begin
                pend_r <= '0;
            end else begin
                pend_r[0] <= bus.en & bus.a;
                for (int i = 1; i < LATENCY; i++) begin
                    pend_r[i] <= pend_r[i-1];
                end
            end
        end
    end

    // Result pulses, saturating counters and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r             <= 1'b0;
            fail_r             <= 1'b0;
            pass_cnt_r         <= '0;
            fail_cnt_r         <= '0;
            err_sticky_r       <= 1'b0;
            first_fail_start_r <= '0;
        end else if (bus.clr) begin
            pass_r             <= 1'b0;
            fail_r             <= 1'b0;
            pass_cnt_r         <= '0;
            fail_cnt_r         <= '0;
            err_sticky_r       <= 1'b0;
            first_fail_start_r <= '0;
        end else begin
            pass_r <= pass_s;
            fail_r <= fail_s;
            if (pass_s && (pass_cnt_r != '1)) begin
                pass_cnt_r <= pass_cnt_r + CNT_ONE;
            end
            if (fail_s && (fail_cnt_r != '1)) begin
                fail_cnt_r <= fail_cnt_r + CNT_ONE;
            end
            if (fail_s && !err_sticky_r) begin
                err_sticky_r       <= 1'b1;
                first_fail_start_r <= ts_r[LATENCY-1];
            end
        end
    end

    assign bus.pass_o           = pass_r;
    assign bus.fail_o           = fail_r;
    assign bus.pass_cnt         = pass_cnt_r;
    assign bus.fail_cnt         = fail_cnt_r;
    assign bus.err_sticky       = err_sticky_r;
    assign bus.first_fail_start = first_fail_start_r;
    assign bus.cyc              = cyc_r;

endmodule

// File: tb/tb_latency_implication_checker.sv
// Directed bench for latency_implication_checker (LATENCY=4, CNT_W=4).
// Edge k is the k-th rising edge after reset release; outputs are sampled
// 1 ns after each edge and compared with hand-computed values.
module tb_latency_implication_checker;

    localparam int LATENCY = 4;
    localparam int CNT_W   = 4;
    localparam int TS_W    = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   ed;

    latency_implication_checker_if #(.CNT_W(CNT_W), .TS_W(TS_W)) bus ();

    latency_implication_checker #(
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W),
        .TS_W   (TS_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s after edge %0d: observed %0d expected %0d", tag, ed - 1, obs, exp);
        end
    endtask

    task automatic step(input logic av, input logic bv, input logic ev, input logic cv);
        bus.a   = av;
        bus.b   = bv;
        bus.en  = ev;
        bus.clr = cv;
        @(posedge clk);
        #1;
        ed++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.en  = 1'b1;
        bus.clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ed    = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ed    = 0;

        // Reset state
        do_reset();
        check("rst_pass_o", bus.pass_o, 1'b0);
        check("rst_fail_o", bus.fail_o, 1'b0);
        check("rst_pass_cnt", bus.pass_cnt, 0);
        check("rst_fail_cnt", bus.fail_cnt, 0);
        check("rst_err", bus.err_sticky, 1'b0);
        check("rst_ffs", bus.first_fail_start, 0);
        check("rst_cyc", bus.cyc, 0);

        // Single pass: a at edge 0, b at edge 4
        for (int k = 0; k < 7; k++) begin
            step(k == 0, k == 4, 1'b1, 1'b0);
            check("t1_pass_o", bus.pass_o, k == 4);
            check("t1_fail_o", bus.fail_o, 1'b0);
        end
        check("t1_pass_cnt", bus.pass_cnt, 1);
        check("t1_fail_cnt", bus.fail_cnt, 0);
        check("t1_err", bus.err_sticky, 1'b0);
        check("t1_cyc", bus.cyc, 7);

        // Single fail: a at edge 2, b low
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(k == 2, 1'b0, 1'b1, 1'b0);
            check("t2_fail_o", bus.fail_o, k == 6);
            check("t2_pass_o", bus.pass_o, 1'b0);
        end
        check("t2_fail_cnt", bus.fail_cnt, 1);
        check("t2_pass_cnt", bus.pass_cnt, 0);
        check("t2_err", bus.err_sticky, 1'b1);
        check("t2_ffs", bus.first_fail_start, 2);

        // Overlapping stream: a 0..9, b 4..13 except 7 and 12
        do_reset();
        for (int k = 0; k < 16; k++) begin
            logic bv;
            bv = (k >= 4) && (k <= 13) && (k != 7) && (k != 12);
            step(k <= 9, bv, 1'b1, 1'b0);
            check("t3_pass_o", bus.pass_o, bv);
            check("t3_fail_o", bus.fail_o, (k == 7) || (k == 12));
            if (k == 7) begin
                check("t3_pass_cnt_e7", bus.pass_cnt, 3);
                check("t3_fail_cnt_e7", bus.fail_cnt, 1);
                check("t3_ffs_e7", bus.first_fail_start, 3);
            end
            if (k == 12) begin
                check("t3_pass_cnt_e12", bus.pass_cnt, 7);
                check("t3_fail_cnt_e12", bus.fail_cnt, 2);
                check("t3_ffs_e12", bus.first_fail_start, 3);
            end
        end
        check("t3_pass_cnt", bus.pass_cnt, 8);
        check("t3_fail_cnt", bus.fail_cnt, 2);
        check("t3_err", bus.err_sticky, 1'b1);
        check("t3_ffs", bus.first_fail_start, 3);

        // Saturation: a=b=1 for 24 edges, passes at 4..23 saturate at 15
        do_reset();
        for (int k = 0; k < 24; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("t4_pass_o", bus.pass_o, k >= 4);
            if (k == 17) check("t4_pass_cnt_e17", bus.pass_cnt, 14);
        end
        check("t4_pass_cnt_sat", bus.pass_cnt, 15);
        // en low: obligations from edges 20..23 mature as fails at 24..27
        for (int k = 24; k < 32; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("t4_fail_o", bus.fail_o, k <= 27);
            check("t4_pass_o_en0", bus.pass_o, 1'b0);
        end
        check("t4_fail_cnt", bus.fail_cnt, 4);
        check("t4_pass_cnt", bus.pass_cnt, 15);
        check("t4_ffs", bus.first_fail_start, 20);
        check("t4_cyc", bus.cyc, 32);

        // clr mid-flight: a at 32..34, clr at 35, b high throughout
        for (int k = 32; k < 35; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_pass_cnt", bus.pass_cnt, 0);
        check("t5_fail_cnt", bus.fail_cnt, 0);
        check("t5_err", bus.err_sticky, 1'b0);
        check("t5_ffs", bus.first_fail_start, 0);
        check("t5_cyc", bus.cyc, 36);
        for (int k = 36; k < 41; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check("t5_pass_o", bus.pass_o, 1'b0);
            check("t5_fail_o", bus.fail_o, 1'b0);
        end
        // clr coincident with maturity (edge 45) and with a new antecedent
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 42; k < 45; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clr_wins", bus.pass_o, 1'b0);
        for (int k = 46; k < 51; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check("t5_clr_ante_pass_o", bus.pass_o, 1'b0);
        end
        check("t5_pass_cnt_end", bus.pass_cnt, 0);
        check("t5_cyc_end", bus.cyc, 51);

        // Async reset between edges with obligations pending
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end
        check("t6_pass_o_pre", bus.pass_o, 1'b1);
        check("t6_pass_cnt_pre", bus.pass_cnt, 2);
        #7;
        rst_n = 1'b0;
        #1;
        check("t6_async_pass_o", bus.pass_o, 1'b0);
        check("t6_async_pass_cnt", bus.pass_cnt, 0);
        check("t6_async_cyc", bus.cyc, 0);
        #6;
        rst_n = 1'b1;
        ed    = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check("t6_late_pass_o", bus.pass_o, 1'b0);
            check("t6_late_fail_o", bus.fail_o, 1'b0);
            if (k == 0) check("t6_cyc_restart", bus.cyc, 1);
        end
        check("t6_pass_cnt", bus.pass_cnt, 0);
        check("t6_cyc", bus.cyc, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
